// File: rtl/inst_fetch_stage_if.sv
// Fetch-stage bus: instruction SRAM port, decode redirect and IF->ID handshake.
interface inst_fetch_stage_if;
    // instruction SRAM
    logic        inst_sram_en;
    logic [3:0]  inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;
    // redirect from decode
    logic        br_valid;
    logic [31:0] br_target;
    // handshake to decode
    logic        ds_allowin;
    logic        fs_to_ds_valid;
    logic [31:0] fs_pc;
    logic [31:0] fs_inst;
    logic        fs_adef;

    // fetch stage side
    modport master (
        output inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata,
        input  inst_sram_rdata,
        input  br_valid, br_target, ds_allowin,
        output fs_to_ds_valid, fs_pc, fs_inst, fs_adef
    );

    // SRAM / decode side
    modport slave (
        input  inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata,
        output inst_sram_rdata,
        output br_valid, br_target, ds_allowin,
        input  fs_to_ds_valid, fs_pc, fs_inst, fs_adef
    );
endinterface

// File: rtl/inst_fetch_stage.sv
// Pre-IF/IF front end: PC generation, synchronous instruction SRAM read and
// a one-entry instruction buffer that holds the fetched word while decode stalls.
module inst_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic                  clk,
    input  logic                  reset,
    inst_fetch_stage_if.master    bus
);

    logic        fs_valid;
    logic [31:0] fs_pc_r;
    logic [31:0] npc_r;
    logic [31:0] inst_buf;
    logic        buf_valid;

    logic        issue;
    logic [31:0] fetch_addr;
    logic        adef;

    // Fetch address selection and read-issue decision
    always_comb begin
        fetch_addr = bus.br_valid ? bus.br_target : npc_r;
        issue      = ~reset & (~fs_valid | bus.ds_allowin | bus.br_valid);
    end

    // IF state: a new issue replaces the IF instruction; on the first stall
    // cycle the SRAM output is still valid, so it is captured into the buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            fs_valid  <= 1'b0;
            fs_pc_r   <= '0;
            npc_r     <= RESET_PC;
            buf_valid <= 1'b0;
            inst_buf  <= '0;
        end else if (issue) begin
            fs_valid  <= 1'b1;
            fs_pc_r   <= fetch_addr;
            npc_r     <= fetch_addr + 32'd4;
            buf_valid <= 1'b0;
        end else if (fs_valid && !buf_valid) begin
            inst_buf  <= bus.inst_sram_rdata;
            buf_valid <= 1'b1;
        end
    end

    // Outputs toward the SRAM and decode
    always_comb begin
        adef                = fs_valid & (|fs_pc_r[1:0]);
        bus.inst_sram_en    = issue;
        bus.inst_sram_we    = '0;
        bus.inst_sram_addr  = fetch_addr;
        bus.inst_sram_wdata = '0;
        bus.fs_to_ds_valid  = fs_valid & ~bus.br_valid;
        bus.fs_pc           = fs_pc_r;
        bus.fs_adef         = adef;
        if (!fs_valid || adef)
            bus.fs_inst = '0;
        else if (buf_valid)
            bus.fs_inst = inst_buf;
        else
            bus.fs_inst = bus.inst_sram_rdata;
    end

endmodule

// File: tb/tb_inst_fetch_stage.sv
// Self-checking bench for inst_fetch_stage: directed pipeline scenarios
// followed by randomized stalls/redirects/resets against a reference model.
module tb_inst_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h1c000000;

    logic clk;
    logic reset;
    inst_fetch_stage_if bus();

    inst_fetch_stage #(.RESET_PC(RST_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hffff0000;
    endfunction

    // SRAM model: one-cycle read latency, garbage when not enabled
    always @(posedge clk) begin
        if (bus.inst_sram_en)
            bus.inst_sram_rdata <= mem_word(bus.inst_sram_addr);
        else
            bus.inst_sram_rdata <= $urandom;
    end

    int unsigned errors = 0;
    int unsigned checks = 0;

    // reference model: what instruction IF holds and where it fetches next
    logic        m_valid;
    logic [31:0] m_pc;
    logic [31:0] m_npc;
    logic [31:0] exp_xfer[$];
    logic [31:0] got_xfer[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rst, input logic allow, input logic br, input logic [31:0] tgt);
        logic        e_en;
        logic [31:0] e_addr;
        logic        e_adef;
        logic [31:0] e_inst;
        reset         = rst;
        bus.ds_allowin = allow;
        bus.br_valid  = br;
        bus.br_target = tgt;
        #4;
        e_en   = !rst && (!m_valid || allow || br);
        e_addr = br ? tgt : m_npc;
        e_adef = m_valid && (m_pc[1:0] != 2'b00);
        e_inst = (m_valid && !e_adef) ? mem_word(m_pc) : 32'h0;
        chk("en",    {31'b0, bus.inst_sram_en}, {31'b0, e_en});
        if (e_en) chk("addr", bus.inst_sram_addr, e_addr);
        chk("we",    {28'b0, bus.inst_sram_we}, 32'h0);
        chk("wdata", bus.inst_sram_wdata, 32'h0);
        chk("to_ds", {31'b0, bus.fs_to_ds_valid}, {31'b0, m_valid && !br});
        chk("pc",    bus.fs_pc, m_pc);
        chk("adef",  {31'b0, bus.fs_adef}, {31'b0, e_adef});
        chk("inst",  bus.fs_inst, e_inst);
        if (m_valid && !br && allow) exp_xfer.push_back(m_pc);
        if (bus.fs_to_ds_valid && allow) got_xfer.push_back(bus.fs_pc);
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b0;
            m_pc    = 32'h0;
            m_npc   = RST_PC;
        end else if (e_en) begin
            m_valid = 1'b1;
            m_pc    = e_addr;
            m_npc   = e_addr + 32'd4;
        end
        #1;
    endtask

    initial begin
        logic found;
        logic [31:0] t;
        reset = 1'b1;
        bus.ds_allowin = 1'b1;
        bus.br_valid = 1'b0;
        bus.br_target = 32'h0;
        m_valid = 1'b0;
        m_pc = 32'h0;
        m_npc = RST_PC;
        @(posedge clk);
        @(posedge clk);
        #1;
        // reset state
        step(1'b1, 1'b1, 1'b0, 32'h0);
        // streaming: 1c000000, 04, 08
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("c0_addr", bus.fs_pc, RST_PC);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("at_08", bus.fs_pc, 32'h1c000008);
        // 3-cycle decode stall holding 1c000008
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("after_stall", bus.fs_pc, 32'h1c00000c);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        // redirect while IF holds 1c000010
        chk("pre_br", bus.fs_pc, 32'h1c000010);
        step(1'b0, 1'b1, 1'b1, 32'h1c000100);
        chk("br_pc", bus.fs_pc, 32'h1c000100);
        // redirect in the second stall cycle (buffer already loaded)
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b1, 32'h1c000200);
        chk("br_stall_pc", bus.fs_pc, 32'h1c000200);
        // misaligned redirect
        step(1'b0, 1'b1, 1'b1, 32'h1c000102);
        chk("mis_pc", bus.fs_pc, 32'h1c000102);
        chk("mis_adef", {31'b0, bus.fs_adef}, 32'h1);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("mis_next", bus.fs_pc, 32'h1c000106);
        // reset while stalled with the buffer loaded
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("rst_restart", bus.fs_pc, RST_PC);

        // wrong-path 1c000010 must never have reached decode
        found = 1'b0;
        foreach (got_xfer[i]) if (got_xfer[i] == 32'h1c000010) found = 1'b1;
        chk("no_xfer_10", {31'b0, found}, 32'h0);

        // randomized phase
        for (int i = 0; i < 400; i++) begin
            t = $urandom;
            if ($urandom_range(3) != 0) t[1:0] = 2'b00;
            step($urandom_range(39) == 0, $urandom_range(3) != 0,
                 $urandom_range(5) == 0, t);
        end

        // transfer sequence as seen by decode
        chk("xfer_count", got_xfer.size(), exp_xfer.size());
        if (got_xfer.size() == exp_xfer.size())
            foreach (exp_xfer[i]) chk("xfer_pc", got_xfer[i], exp_xfer[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/inst_fetch_stage.md
# inst_fetch_stage

Pre-IF/IF front end of the five-stage LoongArch pipeline. It generates the fetch PC, drives the synchronous instruction SRAM (one-cycle read latency), and holds the fetched instruction in a one-entry buffer while decode stalls. It applies decode-stage redirects (branch/jump) and presents `{pc, inst, adef}` to decode through the valid/allowin handshake.

## Interface
- `RESET_PC`, default 32'h1c000000: first fetch address after reset.
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `inst_sram_en` in/out: out 1: read enable.
- `inst_sram_we` out 4: constant 4'b0000.
- `inst_sram_addr` out 32: read address.
- `inst_sram_wdata` out 32: constant 0.
- `inst_sram_rdata` in 32: read data, valid only in the cycle after the enabled read.
- `br_valid` in 1: redirect from decode, already qualified by decode valid and ready-to-go.
- `br_target` in 32: redirect address.
- `ds_allowin` in 1: decode can accept this cycle.
- `fs_to_ds_valid` out 1: IF holds a valid, non-cancelled instruction.
- `fs_pc` out 32: PC of the IF instruction.
- `fs_inst` out 32: instruction word.
- `fs_adef` out 1: fetch address misaligned (`fs_pc[1:0]!=0`).

## Operation
- State: `fs_valid`, `fs_pc`, `npc_r` (next sequential fetch PC), `inst_buf[31:0]`, `buf_valid`.
- Fetch address: `inst_sram_addr = br_valid ? br_target : npc_r`.
- Issue condition: `issue = ~reset & (~fs_valid | ds_allowin | br_valid)`. `inst_sram_en = issue`.
- When `issue`:
  - `fs_valid<=1`
  - `fs_pc<=inst_sram_addr`
  - `npc_r<=inst_sram_addr+4` (mod 2^32)
  - `buf_valid<=0`
- When `~issue & fs_valid & ~buf_valid`:
  - `inst_buf<=inst_sram_rdata`
  - `buf_valid<=1`
  - This captures the data on the first stall cycle, while it is still valid.
- When `~issue` otherwise: all state holds.
- Invariant: `fs_valid & ~buf_valid` means a read for `fs_pc` was issued in the previous cycle.
- Outputs:
  - `fs_inst = ~fs_valid | fs_adef ? 0 : (buf_valid ? inst_buf : inst_sram_rdata)`.
  - `fs_to_ds_valid = fs_valid & ~br_valid`. The IF instruction is wrong-path when decode redirects; LoongArch has no delay slot.
  - `fs_adef = fs_valid & |fs_pc[1:0]`.
- Misaligned redirect: the read is still issued at the misaligned address. The data is ignored and the instruction is flagged via `fs_adef`, so a later exception block can consume it.
- Transfer to decode occurs when `fs_to_ds_valid & ds_allowin`.

## Timing
- Reset values (registered):
  - `fs_valid=0`, `fs_pc=0`, `npc_r=RESET_PC`, `buf_valid=0`, `inst_buf=0`.
- Outputs during reset:
  - `inst_sram_en=0`, `fs_to_ds_valid=0`, `fs_inst=0`, `fs_adef=0`.
- First cycle after reset deasserts (C0): `inst_sram_en=1`, `addr=RESET_PC`.
- C1: `fs_to_ds_valid=1`, `fs_pc=RESET_PC`, `fs_inst=rdata`. The next read `RESET_PC+4` is issued if `ds_allowin`.
- Throughput: one instruction per cycle with no stall. SRAM-to-decode latency is one cycle.
- Stall: no read is issued while `fs_valid & ~ds_allowin & ~br_valid`. Data is captured at the first stall cycle. `fs_inst` stays stable for the whole stall.
- Redirect:
  - In the `br_valid` cycle, the IF instruction is dropped and `br_target` is issued regardless of `ds_allowin`.
  - Next cycle: `fs_pc=br_target`. There is a one-bubble penalty.
- `br_valid` during a stall: the redirect wins, `buf_valid` clears, and the buffered instruction is discarded.
- Reset mid-stall or mid-redirect: reset values are restored next cycle, and no read is issued while reset is high.

## Test plan
- Reset release, `ds_allowin=1` throughout, SRAM model returns `addr^32'hffff0000`:
  - Addresses issued: 1c000000, 1c000004, 1c000008.
  - Decode receives matching pc/inst from C1 onward, one per cycle.
- Pipelined `ds_allowin=0` for 3 cycles at `fs_pc=1c000008`, while the SRAM model drives garbage when `en=0`:
  - `inst_sram_en=0` for 3 cycles.
  - `fs_inst` holds the value for 1c000008.
  - After release, the next issue is 1c00000c.
- `br_valid=1`, `br_target=1c000100` while `fs_pc=1c000010`:
  - `fs_to_ds_valid=0` that cycle.
  - Next cycle `fs_pc=1c000100`.
  - 1c000010 is never transferred.
- `br_valid` in the second cycle of a decode stall:
  - Buffer discarded.
  - Target issued immediately; `fs_pc=target` next cycle.
- `br_target=1c000102`:
  - `fs_adef=1`, `fs_inst=0`, `fs_pc=1c000102`.
  - Next sequential fetch is 1c000106.
- Reset asserted while stalled with `buf_valid=1`:
  - Next cycle `fs_to_ds_valid=0`, `inst_sram_en=0`.
  - After release, the first address is `RESET_PC`.
